// File: rtl/cache_wb_ctrl.sv
// cache_wb_ctrl: N-way set-associative write-back data-cache controller.
//
// Sits between a core load/store port, a word-wide byte-enabled data SRAM
// and an external memory bus. Tags, valid, dirty and per-way age counters
// are kept in registers. The data SRAM holds WORDS_PER_LINE words per way.
// A miss picks a victim (lowest invalid way, otherwise the oldest way with
// ties going to the lowest index). A dirty victim is written back, the line
// is refilled, and the original access then replays as a hit.
//
// Address split: tag | index | word offset | byte offset.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request (valid/ready), we, addr, be, wdata
//   rsp_valid/rsp_rdata one-cycle completion pulse; load data held until the
//                       next rsp_valid
//   sram_*              data SRAM strobe, byte write enables, {way,index,word}
//                       address, write data, read data (SRAM_LATENCY cycles)
//   mem_*               memory bus; mem_req held until mem_ack, mem_rdata
//                       valid together with mem_ack on reads
//   dbg_state           current FSM state
//
// Optional build macro CACHE_WB_CTRL_STATS_EN adds the saturating 32-bit
// counters stat_hits, stat_misses and stat_writebacks (cleared by rst).
//
// Handshakes: a transfer on a valid/ready pair happens in exactly the cycle
// where both are high; once raised, mem_req stays high with mem_addr,
// mem_we and mem_wdata stable until the cycle in which mem_ack is seen.
module cache_wb_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int N_WAYS         = 4,
  parameter int NUM_SETS       = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int SRAM_LATENCY   = 1,
  parameter int AGE_BITS       = 8,
  localparam int BYTES         = DATA_WIDTH / 8,
  localparam int SRAM_AW       = $clog2(N_WAYS * NUM_SETS * WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BYTES-1:0]      req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  sram_en,
  output logic [BYTES-1:0]      sram_we,
  output logic [SRAM_AW-1:0]    sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
`ifdef CACHE_WB_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_writebacks
`endif
);

  localparam int OFF_W = $clog2(BYTES);
  localparam int WRD_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int WAY_W = $clog2(N_WAYS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - WRD_W - OFF_W;
  localparam int CNT_W = $clog2(SRAM_LATENCY + 1) + 1;

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_WB_RD  = 3'd4;
  localparam logic [2:0] S_WB_MEM = 3'd5;
  localparam logic [2:0] S_FILL   = 3'd6;

  logic [2:0]            state;
  logic [CNT_W-1:0]      cnt;       // SRAM latency counter
  logic [WRD_W-1:0]      word_q;    // WB/FILL beat counter, wraps naturally
  logic [WAY_W-1:0]      way_q;     // hit way or victim way of the request
  logic                  we_q;
  logic [TAG_W-1:0]      tag_r_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WRD_W-1:0]      wrd_q;
  logic [BYTES-1:0]      be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TAG_W-1:0]      wb_tag_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [TAG_W-1:0]    tag_q   [NUM_SETS][N_WAYS];
  logic [AGE_BITS-1:0] age_q   [NUM_SETS][N_WAYS];
  logic [N_WAYS-1:0]   valid_q [NUM_SETS];
  logic [N_WAYS-1:0]   dirty_q [NUM_SETS];

  logic [TAG_W-1:0] in_tag;
  logic [IDX_W-1:0] in_idx;
  logic [WRD_W-1:0] in_wrd;
  logic             unused_off;

  assign in_tag     = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign in_idx     = req_addr[OFF_W+WRD_W +: IDX_W];
  assign in_wrd     = req_addr[OFF_W +: WRD_W];
  assign unused_off = ^req_addr[OFF_W-1:0];

  // Lookup and victim choice for the request currently on the port.
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    vict_way;
  logic [AGE_BITS-1:0] max_age;
  logic                inv_found;
  logic [WAY_W-1:0]    acc_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (!hit && valid_q[in_idx][w] && tag_q[in_idx][w] == in_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    // Oldest way first (strict > keeps the lowest index on ties); an invalid
    // way, if any, overrides it.
    vict_way = '0;
    max_age  = age_q[in_idx][0];
    for (int w = 1; w < N_WAYS; w++) begin
      if (age_q[in_idx][w] > max_age) begin
        max_age  = age_q[in_idx][w];
        vict_way = WAY_W'(w);
      end
    end
    inv_found = 1'b0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (!inv_found && !valid_q[in_idx][w]) begin
        inv_found = 1'b1;
        vict_way  = WAY_W'(w);
      end
    end
    acc_way = hit ? hit_way : vict_way;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      word_q    <= '0;
      way_q     <= '0;
      we_q      <= 1'b0;
      tag_r_q   <= '0;
      idx_q     <= '0;
      wrd_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      rdata_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < N_WAYS; w++) begin
          tag_q[s][w] <= '0;
          age_q[s][w] <= '0;
        end
      end
    end else begin
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            tag_r_q <= in_tag;
            idx_q   <= in_idx;
            wrd_q   <= in_wrd;
            be_q    <= req_be;
            wdata_q <= req_wdata;
            way_q   <= acc_way;
            cnt     <= '0;
            word_q  <= '0;
            // The accessed (or about-to-be-filled) way becomes youngest.
            for (int w = 0; w < N_WAYS; w++) begin
              if (WAY_W'(w) == acc_way)
                age_q[in_idx][w] <= '0;
              else if (valid_q[in_idx][w] && age_q[in_idx][w] != {AGE_BITS{1'b1}})
                age_q[in_idx][w] <= age_q[in_idx][w] + 1'b1;
            end
            if (hit) begin
              state <= S_ACCESS;
            end else if (valid_q[in_idx][vict_way] && dirty_q[in_idx][vict_way]) begin
              wb_tag_q <= tag_q[in_idx][vict_way];
              state    <= S_WB_RD;
            end else begin
              state <= S_FILL;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0 && we_q) dirty_q[idx_q][way_q] <= 1'b1;
          if (cnt == CNT_W'(SRAM_LATENCY - 1)) begin
            cnt   <= '0;
            state <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (!we_q) rdata_q <= sram_dout;
          state <= S_IDLE;
        end
        S_WB_RD: begin
          // Read issued at cnt==0, data valid once cnt reaches the latency.
          if (cnt == CNT_W'(SRAM_LATENCY)) begin
            wb_data_q <= sram_dout;
            cnt       <= '0;
            state     <= S_WB_MEM;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WB_MEM: begin
          if (mem_ack) begin
            word_q <= word_q + 1'b1;
            if (word_q == {WRD_W{1'b1}}) begin
              dirty_q[idx_q][way_q] <= 1'b0;
              state                 <= S_FILL;
            end else begin
              state <= S_WB_RD;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            word_q <= word_q + 1'b1;
            if (word_q == {WRD_W{1'b1}}) begin
              tag_q[idx_q][way_q]   <= tag_r_q;
              valid_q[idx_q][way_q] <= 1'b1;
              dirty_q[idx_q][way_q] <= 1'b0;
              cnt                   <= '0;
              state                 <= S_ACCESS;
            end
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    // Load data goes out straight from the SRAM in the RESP cycle and is
    // held from rdata_q afterwards.
    rsp_rdata = (state == S_RESP && !we_q) ? sram_dout : rdata_q;
    dbg_state = state;
    sram_en   = 1'b0;
    sram_we   = '0;
    sram_addr = '0;
    sram_din  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_ACCESS: begin
        if (cnt == '0) begin
          sram_en   = 1'b1;
          sram_addr = {way_q, idx_q, wrd_q};
          if (we_q) begin
            sram_we  = be_q;
            sram_din = wdata_q;
          end
        end
      end
      S_WB_RD: begin
        if (cnt == '0) begin
          sram_en   = 1'b1;
          sram_addr = {way_q, idx_q, word_q};
        end
      end
      S_WB_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wb_tag_q, idx_q, word_q, {OFF_W{1'b0}}};
        mem_wdata = wb_data_q;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {tag_r_q, idx_q, word_q, {OFF_W{1'b0}}};
        if (mem_ack) begin
          sram_en   = 1'b1;
          sram_we   = '1;
          sram_addr = {way_q, idx_q, word_q};
          sram_din  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifdef CACHE_WB_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits       <= '0;
      stat_misses     <= '0;
      stat_writebacks <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        if (hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
        if (!hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      end
      if (state == S_WB_MEM && mem_ack && word_q == {WRD_W{1'b1}} && stat_writebacks != '1)
        stat_writebacks <= stat_writebacks + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// tb_cache_wb_ctrl: self-checking bench for cache_wb_ctrl (default params).
// Memory word at byte address a initially holds 0xA000_0000 + a/4.
module tb_cache_wb_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [2:0]  dbg_state;
`ifdef CACHE_WB_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

  cache_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
`ifdef CACHE_WB_CTRL_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_writebacks(stat_writebacks)
`endif
  );

  int errors = 0;
  int checks = 0;
  int ack_delay = 0;

  // ---------------- models ----------------
  logic [31:0] mem_words [logic [31:0]];  // memory contents written back
  logic [31:0] ref_words [logic [31:0]];  // core-visible stores
  logic [31:0] sram_mem [256];

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];

  logic [31:0] exp_q[$];
  logic        exp_ld_q[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem_words.exists(a) ? mem_words[a] : init_word(a);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return ref_words.exists(a) ? ref_words[a] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      sram_dout <= sram_mem[sram_addr];
    end
  end

  // Memory responder: acks after ack_delay waiting cycles, checks that the
  // request stays stable while it waits, and logs every completed beat.
  int          wait_cnt = 0;
  logic [31:0] held_addr, held_wdata;
  logic        held_we;
  always @(negedge clk) begin
    if (rst || !mem_req || mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) begin
        held_addr  = mem_addr;
        held_we    = mem_we;
        held_wdata = mem_wdata;
      end else begin
        checks++;
        if (mem_addr !== held_addr || mem_we !== held_we || mem_wdata !== held_wdata) begin
          errors++;
          $display("FAIL mem_stable got addr=%h we=%b want addr=%h we=%b", mem_addr, mem_we, held_addr, held_we);
        end
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) mem_words[mem_addr] = mem_wdata;
        else mem_rdata = mem_word(mem_addr);
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_we ? mem_wdata : mem_rdata);
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    logic        l;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected got rsp_valid=1 want none pending");
      end else begin
        e = exp_q.pop_front();
        l = exp_ld_q.pop_front();
        if (l) begin
          checks++;
          if (rsp_rdata !== e) begin
            errors++;
            $display("FAIL rsp_data got=%h want=%h", rsp_rdata, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output int lat);
    logic [31:0] wa, old, nw;
    int n;
    wa = {addr[31:2], 2'b00};
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!req_ready) begin errors++; $display("FAIL req_accept got ready=0 want 1 addr=%h", addr); end
    old = exp_word(wa);
    nw  = old;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) nw[8*b +: 8] = wdata[8*b +: 8];
      ref_words[wa] = nw;
    end
    exp_q.push_back(we ? 32'h0 : old);
    exp_ld_q.push_back(!we);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 2000) begin @(negedge clk); lat++; end
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL rsp_timeout got none want rsp addr=%h", addr); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp got valid=%b data=%h want 0", rsp_valid, rsp_rdata);
    end
    checks++;
    if (sram_en !== 1'b0 || sram_we !== 4'h0 || sram_addr !== 8'h0 || sram_din !== 32'h0) begin
      errors++; $display("FAIL reset_sram got en=%b we=%h want 0", sram_en, sram_we);
    end
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_mem got req=%b addr=%h want 0", mem_req, mem_addr);
    end
    checks++;
    if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL init_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_cold_load();
    int lat;
    clear_log();
    do_req(1'b0, 32'h100, 4'hF, 32'h0, lat);
    checks++;
    if (log_addr.size() != 4) begin errors++; $display("FAIL cold_beats got=%0d want=4", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size() || log_we[i] !== 1'b0 || log_addr[i] !== 32'h100 + 4*i) begin
        errors++; $display("FAIL cold_read%0d want read addr=%h", i, 32'h100 + 4*i);
      end
    end
    clear_log();
    do_req(1'b0, 32'h100, 4'hF, 32'h0, lat);
    checks++;
    if (lat != 2) begin errors++; $display("FAIL hit_latency got=%0d want=2", lat); end
    checks++;
    if (log_addr.size() != 0) begin errors++; $display("FAIL hit_traffic got=%0d want=0", log_addr.size()); end
  endtask

  task automatic test_store_hit();
    int lat;
    clear_log();
    do_req(1'b1, 32'h104, 4'b0011, 32'hFFFF_1234, lat);
    do_req(1'b0, 32'h104, 4'hF, 32'h0, lat);
    checks++;
    if (rsp_rdata !== 32'hA000_1234) begin errors++; $display("FAIL store_merge got=%h want=a0001234", rsp_rdata); end
    checks++;
    if (log_addr.size() != 0) begin errors++; $display("FAIL store_traffic got=%0d want=0", log_addr.size()); end
  endtask

  // Set 1 lines live at (tag << 8) | 0x10.
  task automatic test_lru_clean();
    int lat;
    for (int t = 1; t <= 4; t++) do_req(1'b0, (t << 8) | 32'h10, 4'hF, 32'h0, lat);
    for (int t = 2; t <= 4; t++) do_req(1'b0, (t << 8) | 32'h10, 4'hF, 32'h0, lat);
    clear_log();
    do_req(1'b0, 32'h510, 4'hF, 32'h0, lat);
    checks++;
    if (log_addr.size() != 4) begin errors++; $display("FAIL lru_beats got=%0d want=4", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size() || log_we[i] !== 1'b0 || log_addr[i] !== 32'h510 + 4*i) begin
        errors++; $display("FAIL lru_read%0d want read addr=%h", i, 32'h510 + 4*i);
      end
    end
    clear_log();
    do_req(1'b0, 32'h110, 4'hF, 32'h0, lat);
    checks++;
    if (log_addr.size() != 4 || log_addr[0] !== 32'h110 || log_we[0] !== 1'b0) begin
      errors++; $display("FAIL lru_evicted got beats=%0d want 4 reads from 110", log_addr.size());
    end
  endtask

  // Set 1 now: tag5, tag1, tag3 (oldest after the touches below), tag4.
  task automatic test_dirty_wb();
    int lat;
    logic [31:0] d [4];
    for (int i = 0; i < 4; i++) begin
      d[i] = $urandom_range(32'h7FFF_FFFF, 0);
      do_req(1'b1, 32'h310 + 4*i, 4'hF, d[i], lat);
    end
    do_req(1'b0, 32'h510, 4'hF, 32'h0, lat);
    do_req(1'b0, 32'h110, 4'hF, 32'h0, lat);
    do_req(1'b0, 32'h410, 4'hF, 32'h0, lat);
    clear_log();
    do_req(1'b0, 32'h610, 4'hF, 32'h0, lat);
    checks++;
    if (log_addr.size() != 8) begin errors++; $display("FAIL wb_beats got=%0d want=8", log_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= log_addr.size() || log_we[i] !== 1'b1 || log_addr[i] !== 32'h310 + 4*i || log_data[i] !== d[i]) begin
        errors++; $display("FAIL wb_write%0d want write addr=%h data=%h", i, 32'h310 + 4*i, d[i]);
      end
      checks++;
      if (i + 4 >= log_addr.size() || log_we[i+4] !== 1'b0 || log_addr[i+4] !== 32'h610 + 4*i) begin
        errors++; $display("FAIL wb_read%0d want read addr=%h", i, 32'h610 + 4*i);
      end
    end
    do_req(1'b0, 32'h318, 4'hF, 32'h0, lat);
  endtask

  task automatic test_slow_mem();
    int lat;
    ack_delay = 5;
    clear_log();
    do_req(1'b0, 32'h2008, 4'hF, 32'h0, lat);
    checks++;
    if (log_addr.size() != 4 || log_addr[3] !== 32'h200C) begin
      errors++; $display("FAIL slow_beats got=%0d want 4 reads ending 200c", log_addr.size());
    end
    checks++;
    if (lat < 24) begin errors++; $display("FAIL slow_latency got=%0d want>=24", lat); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_fill();
    int n, lat;
    clear_log();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", req_ready); end
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!(log_addr.size() == 1 && mem_req) && n < 100) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL midrst_beat2 got timeout want 2nd fill beat"); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || req_ready !== 1'b0 || sram_en !== 1'b0 || rsp_rdata !== 32'h0 || dbg_state !== 3'd0) begin
      errors++; $display("FAIL midrst_outputs got req=%b ready=%b en=%b state=%0d want 0", mem_req, req_ready, sram_en, dbg_state);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_ld_q.delete();
    ref_words = mem_words;   // the dirty line in set 0 is lost with the reset
    clear_log();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL midrst_quiet got mem_req=1 want 0"); end
    end
    do_req(1'b0, 32'h3000, 4'hF, 32'h0, lat);
    checks++;
    if (log_addr.size() != 4 || log_addr[0] !== 32'h3000 || log_we[0] !== 1'b0) begin
      errors++; $display("FAIL midrst_refill got beats=%0d want 4 reads from 3000", log_addr.size());
    end
    clear_log();
    do_req(1'b0, 32'h104, 4'hF, 32'h0, lat);
    checks++;
    if (rsp_rdata !== 32'hA000_0041 || log_addr.size() != 4) begin
      errors++; $display("FAIL midrst_invalid got data=%h beats=%0d want a0000041 and 4", rsp_rdata, log_addr.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h3000; req_be = 4'hF;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    exp_q.push_back(exp_word(32'h3000)); exp_ld_q.push_back(1'b1);
    exp_q.push_back(exp_word(32'h3004)); exp_ld_q.push_back(1'b1);
    @(negedge clk);
    req_addr = 32'h3004;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b want=1", req_ready); end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp got=%b want=1", rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_lru_clean();
    test_dirty_wb();
    test_slow_mem();
    test_reset_mid_fill();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
